// File: rtl/ibex_ex_block_seq.sv
// ibex_ex_block_seq: handshaked execute unit with single-cycle ALU ops and
// iterative shift-add multiply / restoring divide.
// Optional macro IBEX_EX_CAP_TAG_EN adds operand_a_tag_i / result_tag_o so that
// ADD/SUB propagate the capability tag of operand A.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | no op held, ready for a new one
// BUSY   | iterative MUL/DIVU/REMU in progress
// DONE   | result held until writeback takes it
module ibex_ex_block_seq #(
    parameter int unsigned DATA_W    = 32,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] operand_a_i,
    input  logic [DATA_W-1:0] operand_b_i,
`ifdef IBEX_EX_CAP_TAG_EN
    input  logic              operand_a_tag_i,
    output logic              result_tag_o,
`endif
    input  logic              kill_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              illegal_o,
    output logic              busy_o
);

    localparam int unsigned CW = $clog2(DATA_W) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIVU = 4'd7;
    localparam logic [3:0] OP_REMU = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              illegal_q, illegal_d;
    logic              tag_q, tag_d;

    logic              accept;
    logic              start_iter;
    logic              div_by_zero;
    logic [DATA_W-1:0] quick_res;
    logic              quick_ill;
    logic              iter_last;
    logic [DATA_W-1:0] iter_res;
    logic              tag_in;

`ifdef IBEX_EX_CAP_TAG_EN
    assign tag_in       = operand_a_tag_i;
    assign result_tag_o = tag_q;
`else
    assign tag_in = 1'b0;
`endif

    assign ready_o        = (state_q == S_IDLE) | ((state_q == S_DONE) & result_ready_i);
    assign result_valid_o = (state_q == S_DONE);
    assign busy_o         = (state_q == S_BUSY);
    assign result_o       = result_q;
    assign illegal_o      = illegal_q;

    // kill wins over any accept in the same cycle
    assign accept      = valid_i & ready_o & ~kill_i;
    assign div_by_zero = ((op_i == OP_DIVU) | (op_i == OP_REMU)) & (operand_b_i == '0);
    assign start_iter  = accept & MULDIV_EN & ~div_by_zero &
                         ((op_i == OP_MUL) | (op_i == OP_DIVU) | (op_i == OP_REMU));

    // Results that complete on the accept edge (ALU, illegal, divide by zero)
    always_comb begin
        quick_res = '0;
        quick_ill = 1'b0;
        case (op_i)
            OP_ADD:  quick_res = operand_a_i + operand_b_i;
            OP_SUB:  quick_res = operand_a_i - operand_b_i;
            OP_AND:  quick_res = operand_a_i & operand_b_i;
            OP_OR:   quick_res = operand_a_i | operand_b_i;
            OP_XOR:  quick_res = operand_a_i ^ operand_b_i;
            OP_SLTU: quick_res = {{(DATA_W-1){1'b0}}, (operand_a_i < operand_b_i)};
            OP_MUL:  quick_ill = ~MULDIV_EN;
            OP_DIVU: begin
                if (MULDIV_EN) quick_res = '1;
                else           quick_ill = 1'b1;
            end
            OP_REMU: begin
                if (MULDIV_EN) quick_res = operand_a_i;
                else           quick_ill = 1'b1;
            end
            default: quick_ill = 1'b1;
        endcase
    end

    // Next-state and result-capture logic
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        tag_d     = tag_q;
        if (kill_i) begin
            state_d = S_IDLE;
            tag_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (start_iter) begin
                            state_d = S_BUSY;
                        end else begin
                            state_d   = S_DONE;
                            result_d  = quick_res;
                            illegal_d = quick_ill;
                            tag_d     = tag_in & ((op_i == OP_ADD) | (op_i == OP_SUB));
                        end
                    end else if ((state_q == S_DONE) & result_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (iter_last) begin
                        state_d   = S_DONE;
                        result_d  = iter_res;
                        illegal_d = 1'b0;
                        tag_d     = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and held-result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            tag_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            tag_q     <= tag_d;
        end
    end

    if (MULDIV_EN) begin : g_muldiv
        // acc: product accumulator / partial remainder
        // opa: shifting multiplicand / dividend-then-quotient
        // opb: shifting multiplier / divisor
        logic [DATA_W-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic              is_mul_q, is_mul_d, is_rem_q, is_rem_d;
        logic [DATA_W-1:0] mul_acc, div_rem, div_quot;
        logic [DATA_W:0]   rem_shift, rem_diff;
        logic              rem_ge;

        // One shift-add or restore-divide step per BUSY cycle
        always_comb begin
            acc_d    = acc_q;
            opa_d    = opa_q;
            opb_d    = opb_q;
            cnt_d    = cnt_q;
            is_mul_d = is_mul_q;
            is_rem_d = is_rem_q;

            mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);
            rem_shift = {acc_q, opa_q[DATA_W-1]};
            rem_diff  = rem_shift - {1'b0, opb_q};
            rem_ge    = (rem_shift >= {1'b0, opb_q});
            div_rem   = rem_ge ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
            div_quot  = {opa_q[DATA_W-2:0], rem_ge};

            if (start_iter) begin
                acc_d    = '0;
                opa_d    = operand_a_i;
                opb_d    = operand_b_i;
                cnt_d    = CW'(DATA_W);
                is_mul_d = (op_i == OP_MUL);
                is_rem_d = (op_i == OP_REMU);
            end else if (state_q == S_BUSY) begin
                cnt_d = cnt_q - 1'b1;
                if (is_mul_q) begin
                    acc_d = mul_acc;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    acc_d = div_rem;
                    opa_d = div_quot;
                end
            end
        end

        assign iter_last = (cnt_q == CW'(1));
        assign iter_res  = is_mul_q ? mul_acc : (is_rem_q ? div_rem : div_quot);

        // Iteration registers
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                acc_q    <= '0;
                opa_q    <= '0;
                opb_q    <= '0;
                cnt_q    <= '0;
                is_mul_q <= 1'b0;
                is_rem_q <= 1'b0;
            end else begin
                acc_q    <= acc_d;
                opa_q    <= opa_d;
                opb_q    <= opb_d;
                cnt_q    <= cnt_d;
                is_mul_q <= is_mul_d;
                is_rem_q <= is_rem_d;
            end
        end
    end else begin : g_no_muldiv
        assign iter_last = 1'b0;
        assign iter_res  = '0;
    end

endmodule

// File: tb/tb_ibex_ex_block_seq.sv
module tb_ibex_ex_block_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [3:0]   op_i = 4'd0;
    logic [W-1:0] operand_a_i = '0;
    logic [W-1:0] operand_b_i = '0;
    logic         kill_i = 1'b0;
    logic         result_valid_o;
    logic         result_ready_i = 1'b1;
    logic [W-1:0] result_o;
    logic         illegal_o;
    logic         busy_o;
`ifdef IBEX_EX_CAP_TAG_EN
    logic         tag_i = 1'b0;
    logic         result_tag_o;
`endif

    ibex_ex_block_seq #(.DATA_W(W), .MULDIV_EN(1'b1)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .op_i           (op_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
`ifdef IBEX_EX_CAP_TAG_EN
        .operand_a_tag_i(tag_i),
        .result_tag_o   (result_tag_o),
`endif
        .kill_i         (kill_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .illegal_o      (illegal_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ill;
        logic         tag;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: compare each consumed result with the oldest expectation
    always @(negedge clk) begin
        if (!rst_i && result_valid_o && result_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'(result_o), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 64'(result_o), 64'(e.res));
                chk("illegal", 64'(illegal_o), 64'(e.ill));
`ifdef IBEX_EX_CAP_TAG_EN
                chk("tag", 64'(result_tag_o), 64'(e.tag));
`endif
            end
        end
    end

    // Offer one op, wait for acceptance; returns whether result_valid_o was high in the accept cycle
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic tg, input bit push, input logic [W-1:0] eres,
                        input logic eill, input logic etag, output bit rv_at_acc);
        bit got;
        got = 0;
        rv_at_acc = 0;
        @(posedge clk); #1;
        valid_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
`ifdef IBEX_EX_CAP_TAG_EN
        tag_i = tg;
`endif
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_o) begin got = 1; rv_at_acc = result_valid_o; break; end
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        if (push) sb.push_back('{res: eres, ill: eill, tag: etag});
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_result(output int n, output int busy_n, output bit rdy_busy);
        n = 0; busy_n = 0; rdy_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (busy_o) begin busy_n++; if (ready_o) rdy_busy = 1; end
            if (result_valid_o) break;
        end
        if (!result_valid_o) n = 999;
    endtask

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[] = '{
        '{op: 4'd0,  a: 32'hFFFF_FFFF, b: 32'd2,          res: 32'h0000_0001, ill: 1'b0, lat: 1},
        '{op: 4'd1,  a: 32'h0,         b: 32'd1,          res: 32'hFFFF_FFFF, ill: 1'b0, lat: 1},
        '{op: 4'd2,  a: 32'hFF00_FF00, b: 32'h0FF0_0FF0,  res: 32'h0F00_0F00, ill: 1'b0, lat: 1},
        '{op: 4'd3,  a: 32'hF000_0000, b: 32'h1,          res: 32'hF000_0001, ill: 1'b0, lat: 1},
        '{op: 4'd5,  a: 32'd3,         b: 32'd5,          res: 32'd1,         ill: 1'b0, lat: 1},
        '{op: 4'd5,  a: 32'd5,         b: 32'd3,          res: 32'd0,         ill: 1'b0, lat: 1},
        '{op: 4'd12, a: 32'd9,         b: 32'd9,          res: 32'd0,         ill: 1'b1, lat: 1},
        '{op: 4'd7,  a: 32'd5,         b: 32'd0,          res: 32'hFFFF_FFFF, ill: 1'b0, lat: 1},
        '{op: 4'd8,  a: 32'd5,         b: 32'd0,          res: 32'd5,         ill: 1'b0, lat: 1},
        '{op: 4'd6,  a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF,  res: 32'd1,         ill: 1'b0, lat: 33},
        '{op: 4'd6,  a: 32'h0001_0000, b: 32'h0001_0000,  res: 32'd0,         ill: 1'b0, lat: 33},
        '{op: 4'd7,  a: 32'hFFFF_FFFF, b: 32'h10,         res: 32'h0FFF_FFFF, ill: 1'b0, lat: 33},
        '{op: 4'd8,  a: 32'hFFFF_FFFF, b: 32'h10,         res: 32'hF,         ill: 1'b0, lat: 33}
    };

    initial begin
        int  n, bn;
        bit  rb, rv, seen;

        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(result_valid_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_illegal", 64'(illegal_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);

        // directed vectors, result_ready_i held high
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1, vecs[i].res, vecs[i].ill, 1'b0, rv);
            wait_result(n, bn, rb);
            chk($sformatf("latency_v%0d", i), 64'(n), 64'(vecs[i].lat));
        end

        // MUL 7*6: busy 32 cycles, ready low throughout
        send(4'd6, 32'd7, 32'd6, 1'b0, 1, 32'd42, 1'b0, 1'b0, rv);
        wait_result(n, bn, rb);
        chk("mul_latency", 64'(n), 64'd33);
        chk("mul_busy_cycles", 64'(bn), 64'd32);
        chk("mul_ready_in_busy", 64'(rb), 64'd0);

        // DIVU then REMU back-to-back: second accepted in DONE cycle of first
        send(4'd7, 32'd100, 32'd7, 1'b0, 1, 32'd14, 1'b0, 1'b0, rv);
        send(4'd8, 32'd100, 32'd7, 1'b0, 1, 32'd2, 1'b0, 1'b0, rv);
        chk("b2b_accept_in_done", 64'(rv), 64'd1);
        wait_result(n, bn, rb);
        chk("b2b_remu_latency", 64'(n), 64'd33);

        // stalled XOR: result must hold for 5 cycles
        @(posedge clk); #1 result_ready_i = 1'b0;
        send(4'd4, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 1, 32'h0000_FF00, 1'b0, 1'b0, rv);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(result_valid_o), 64'd1);
            chk("stall_result", 64'(result_o), 64'h0000_FF00);
            chk("stall_ready", 64'(ready_o), 64'd0);
        end
        @(posedge clk); #1 result_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_idle_valid", 64'(result_valid_o), 64'd0);
        chk("release_idle_ready", 64'(ready_o), 64'd1);

        // kill at BUSY cycle 10, then the same with reset
        for (int k = 0; k < 2; k++) begin
            send(4'd6, 32'd7, 32'd6, 1'b0, 0, '0, 1'b0, 1'b0, rv);
            repeat (9) @(posedge clk);
            #1;
            if (k == 0) kill_i = 1'b1; else rst_i = 1'b1;
            @(posedge clk); #1;
            kill_i = 1'b0; rst_i = 1'b0;
            @(negedge clk);
            chk($sformatf("abort%0d_busy", k), 64'(busy_o), 64'd0);
            chk($sformatf("abort%0d_ready", k), 64'(ready_o), 64'd1);
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (result_valid_o) seen = 1;
            end
            chk($sformatf("abort%0d_no_valid", k), 64'(seen), 64'd0);
        end

        // accept coinciding with kill is discarded
        @(posedge clk); #1;
        valid_i = 1'b1; op_i = 4'd0; operand_a_i = 32'd1; operand_b_i = 32'd1; kill_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        @(negedge clk);
        chk("kill_accept_valid", 64'(result_valid_o), 64'd0);
        chk("kill_accept_busy", 64'(busy_o), 64'd0);

`ifdef IBEX_EX_CAP_TAG_EN
        send(4'd0, 32'h100, 32'h4, 1'b1, 1, 32'h104, 1'b0, 1'b1, rv);
        wait_result(n, bn, rb);
        send(4'd2, 32'hFF, 32'h0F, 1'b1, 1, 32'h0F, 1'b0, 1'b0, rv);
        wait_result(n, bn, rb);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ibex_ex_block_seq.md
Name: ibex_ex_block_seq

Overview:
Parametrised, handshaked execute unit for the CHERI-extended ibex core. It sits between ID and writeback. It accepts one operation at a time over valid/ready, computes single-cycle logic/arithmetic ops or iterative multiply/divide, and holds a registered result until writeback takes it. It succeeds the combinational execute block by adding width generality, back-pressure, abort, and explicit multi-cycle sequencing.

Parameters:
DATA_W, 32, operand/result width; any value 8..64.
MULDIV_EN, 1, 1 = iterative MUL/DIVU/REMU present; 0 = those ops flagged illegal.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
valid_i  input  1  operation offered
ready_o  output  1  unit can accept this cycle
op_i  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLTU, 6 MUL (low half), 7 DIVU, 8 REMU; 9..15 illegal
operand_a_i  input  DATA_W  source A
operand_b_i  input  DATA_W  source B
kill_i  input  1  abort in-flight op (pipeline flush)
result_valid_o  output  1  result held
result_ready_i  input  1  writeback consumes result
result_o  output  DATA_W  result
illegal_o  output  1  op was illegal; qualified by result_valid_o
busy_o  output  1  iterative op in progress

Behaviour:
- Reset: the block uses one clock, clk_i, and a synchronous, active-high reset, rst_i. When rst_i is high at a clock edge, the next state is IDLE. result_valid_o=0, result_o=0, illegal_o=0, busy_o=0, and all iteration registers are cleared.
- FSM states:
  - IDLE: ready_o=1.
  - BUSY: ready_o=0, busy_o=1.
  - DONE: result_valid_o=1; ready_o=result_ready_i.
- Accept: a transfer happens when valid_i & ready_o. Operands and op are captured at that edge.
- Single-cycle ops (ADD/SUB/AND/OR/XOR/SLTU/illegal): go to DONE the next edge, so latency is 1 cycle.
  - ADD/SUB wrap modulo 2^DATA_W.
  - SLTU gives a zero-extended 1 or 0.
  - Illegal ops give result 0 and illegal_o=1.
- MUL: shift-add over DATA_W BUSY cycles, then DONE. Accept-to-result_valid latency is DATA_W+1 cycles. Only the low DATA_W bits are kept.
- DIVU/REMU: restoring division over DATA_W BUSY cycles, same latency as MUL.
- Divide by zero: skips BUSY and reaches DONE in 1 cycle.
  - DIVU returns all ones.
  - REMU returns operand_a.
- Iteration counter: width $clog2(DATA_W)+1. Loaded with DATA_W on accept and decremented each BUSY cycle. The exit condition is counter==1 at the edge.
- DONE to IDLE: on result_ready_i without a new accept.
- DONE to DONE or BUSY: a simultaneous result_ready_i and a new valid_i accept (back-to-back) goes directly to the new op's next state, with no bubble.
- Stable outputs: result_o and illegal_o stay stable while result_valid_o=1 and result_ready_i=0.
- kill_i: in any state, kill_i forces the next state to IDLE and drops result_valid_o. An accept in the same cycle as kill_i is discarded. kill_i has priority over accept and over result_ready_i.
- MULDIV_EN=0: MUL/DIVU/REMU behave as illegal ops (1-cycle, result 0, illegal_o=1). No iteration datapath is generated.
- Reset mid-operation (BUSY or DONE): the partial result is discarded and no result_valid_o pulse follows.

Optional Feature:
Macro: IBEX_EX_CAP_TAG_EN.
- Defined: the block adds input operand_a_tag_i (1 bit) and output result_tag_o (1 bit, reset 0).
  - result_tag_o = captured tag & (op is ADD or SUB). Pointer arithmetic preserves the capability tag; every other op, including illegal and kill, clears it.
  - result_tag_o follows the same valid/stall timing as result_o.
- Undefined: both ports are absent and no tag storage is generated.

Test Plan:
1. Reset, then ADD a=0xFFFFFFFF, b=2, result_ready_i=1 -> result_valid_o high 1 cycle after accept, result_o=0x00000001, illegal_o=0.
2. MUL a=7, b=6 (DATA_W=32) -> busy_o high for 32 cycles; result_valid_o rises 33 cycles after accept; result_o=42; ready_o=0 throughout BUSY.
3. DIVU a=100, b=7, then REMU a=100, b=7 back-to-back with result_ready_i=1 -> results 14 then 2; the second op is accepted in the DONE cycle of the first, with no idle cycle.
4. DIVU a=5, b=0 -> result 0xFFFFFFFF after 1 cycle. REMU a=5, b=0 -> result 5 after 1 cycle.
5. Hold result_ready_i=0 for 5 cycles after an XOR of 0xF0F0 and 0x0FF0 -> result_o stays 0x0000FF00, ready_o=0. Release -> consumed; IDLE next cycle.
6. Start MUL; assert kill_i at BUSY cycle 10 -> IDLE next cycle, no result_valid_o. Repeat with rst_i instead of kill_i -> same outcome. With IBEX_EX_CAP_TAG_EN defined: ADD with tag=1 gives result_tag_o=1; AND with tag=1 gives result_tag_o=0.
